// File: rtl/gpio_input_conditioner_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
// Contents:
//   DEFAULT_DEBOUNCE_CYCLES - default count of consecutive samples before a new
//                             level is accepted (1 ms at 100 MHz).
//   clog2                   - bit width needed to hold values 0..v-1.
package gpio_cond_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 100000;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Pad-side and SoC-side signals of the GPIO input conditioner.
// Modports:
//   master - drives pad_i, bypass_i, event_clear_i, irq_en_i; observes the
//            conditioned outputs.
//   slave  - the conditioner itself.
// Signals:
//   pad_i         raw asynchronous pad inputs
//   bypass_i      per-bit bypass of the debounce counter
//   event_clear_i write-1-to-clear strobe for event_o
//   irq_en_i      per-bit interrupt enable
//   level_o       debounced level (SoC gpio_read)
//   rise_o/fall_o one-cycle pulses on accepted transitions
//   event_o       sticky per-bit event flags
//   irq_o         OR of enabled event flags
interface gpio_input_conditioner_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] pad_i;
  logic [WIDTH-1:0] bypass_i;
  logic [WIDTH-1:0] event_clear_i;
  logic [WIDTH-1:0] irq_en_i;
  logic [WIDTH-1:0] level_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] event_o;
  logic             irq_o;

  modport master (
    output pad_i, bypass_i, event_clear_i, irq_en_i,
    input  level_o, rise_o, fall_o, event_o, irq_o
  );

  modport slave (
    input  pad_i, bypass_i, event_clear_i, irq_en_i,
    output level_o, rise_o, fall_o, event_o, irq_o
  );

endinterface

// File: rtl/gpio_input_conditioner_debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, consecutive-sample debounce
// counter, registered level, rise/fall pulses and a sticky event flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pad          raw asynchronous input
//   bypass       skip the debounce counter (synchronise only)
//   event_clear  clears the event flag at the next edge
//   level        debounced level
//   rise, fall   one-cycle pulses on accepted transitions
//   ev           sticky event flag
module debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  input  logic bypass,
  input  logic event_clear,
  output logic level,
  output logic rise,
  output logic fall,
  output logic ev
);

  localparam int unsigned      CNT_W   = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s0;
  logic             s1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // A new level is taken either every cycle in bypass, or once s1 has
  // differed from the level for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    accept = 1'b0;
    if (s1 != level) accept = bypass || (cnt == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0    <= INIT_LEVEL;
      s1    <= INIT_LEVEL;
      level <= INIT_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      ev    <= 1'b0;
    end else begin
      s0   <= pad;
      s1   <= s0;
      rise <= accept &  s1;
      fall <= accept & ~s1;
      if (accept) level <= s1;
      // Bypass or any agreeing sample discards progress; cnt stops at CNT_MAX
      // because reaching it with a differing sample always accepts.
      if (bypass || accept || (s1 == level)) cnt <= '0;
      else                                   cnt <= cnt + CNT_W'(1);
      // Event flag follows the registered pulse; a set beats a same-cycle clear.
      if (rise || fall)      ev <= 1'b1;
      else if (event_clear)  ev <= 1'b0;
    end
  end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Per-bit GPIO input conditioner: WIDTH independent debounce_bit instances
// plus the interrupt reduction.
// Ports:
//   mainClk      single clock, rising edge
//   asyncResetN  asynchronous active-low reset
//   bus          gpio_input_conditioner_if.slave (pads, controls, outputs)
// Parameters:
//   WIDTH, DEBOUNCE_CYCLES (>=1), INIT_LEVEL (reset level per bit)
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int unsigned      WIDTH           = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INIT_LEVEL      = '0
) (
  input logic                      mainClk,
  input logic                      asyncResetN,
  gpio_input_conditioner_if.slave  bus
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INIT_LEVEL      (INIT_LEVEL[i])
    ) u_bit (
      .clk         (mainClk),
      .rst_n       (asyncResetN),
      .pad         (bus.pad_i[i]),
      .bypass      (bus.bypass_i[i]),
      .event_clear (bus.event_clear_i[i]),
      .level       (level[i]),
      .rise        (rise[i]),
      .fall        (fall[i]),
      .ev          (ev[i])
    );
  end

  assign bus.level_o = level;
  assign bus.rise_o  = rise;
  assign bus.fall_o  = fall;
  assign bus.event_o = ev;
  assign bus.irq_o   = |(ev & bus.irq_en_i);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with WIDTH=8, DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point. "Edge n" counts rising edges after the input change.
module tb_gpio_input_conditioner;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gpio_input_conditioner_if #(.WIDTH(8)) bus ();

  gpio_input_conditioner #(
    .WIDTH           (8),
    .DEBOUNCE_CYCLES (4),
    .INIT_LEVEL      (8'h00)
  ) dut (
    .mainClk     (clk),
    .asyncResetN (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus.pad_i         = 8'hFF;
    bus.bypass_i      = 8'h00;
    bus.event_clear_i = 8'h00;
    bus.irq_en_i      = 8'h00;

    // Reset with pads high
    #3;
    chk("rst_level", bus.level_o, 8'h00);
    chk("rst_event", bus.event_o, 8'h00);
    chk("rst_rise",  bus.rise_o,  8'h00);
    chk("rst_irq",   bus.irq_o,   1'b0);
    tick(2);
    chk("rst_hold_level", bus.level_o, 8'h00);
    rst_n = 1'b1;
    tick(5);
    chk("rel_e5_level", bus.level_o, 8'h00);
    tick(1);
    chk("rel_e6_level", bus.level_o, 8'hFF);
    chk("rel_e6_rise",  bus.rise_o,  8'hFF);
    chk("rel_e6_event", bus.event_o, 8'h00);
    tick(1);
    chk("rel_e7_rise",  bus.rise_o,  8'h00);
    chk("rel_e7_event", bus.event_o, 8'hFF);
    chk("rel_e7_irq_masked", bus.irq_o, 1'b0);
    bus.event_clear_i = 8'hFF;
    tick(1);
    chk("clr_all_event", bus.event_o, 8'h00);
    bus.event_clear_i = 8'h00;

    // All pads fall
    bus.pad_i = 8'h00;
    tick(5);
    chk("fall_e5_level", bus.level_o, 8'hFF);
    tick(1);
    chk("fall_e6_level", bus.level_o, 8'h00);
    chk("fall_e6_fall",  bus.fall_o,  8'hFF);
    chk("fall_e6_rise",  bus.rise_o,  8'h00);
    tick(1);
    chk("fall_e7_fall",  bus.fall_o,  8'h00);
    chk("fall_e7_event", bus.event_o, 8'hFF);
    bus.event_clear_i = 8'hFF;
    tick(1);
    bus.event_clear_i = 8'h00;

    // 3-cycle glitch on bit 0 is rejected
    bus.pad_i = 8'h01;
    tick(3);
    bus.pad_i = 8'h00;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("glitch_level", bus.level_o, 8'h00);
      chk("glitch_rise",  bus.rise_o,  8'h00);
    end
    chk("glitch_event", bus.event_o, 8'h00);

    // 4-cycle pulse on bit 0 is accepted, then falls back
    bus.pad_i = 8'h01;
    tick(4);
    bus.pad_i = 8'h00;
    tick(1);
    chk("pulse4_e5_level", bus.level_o, 8'h00);
    tick(1);
    chk("pulse4_e6_level", bus.level_o, 8'h01);
    chk("pulse4_e6_rise",  bus.rise_o,  8'h01);
    tick(1);
    chk("pulse4_e7_rise",  bus.rise_o,  8'h00);
    chk("pulse4_e7_event", bus.event_o, 8'h01);
    tick(2);
    chk("pulse4_e9_level", bus.level_o, 8'h01);
    tick(1);
    chk("pulse4_e10_level", bus.level_o, 8'h00);
    chk("pulse4_e10_fall",  bus.fall_o,  8'h01);
    bus.event_clear_i = 8'hFF;
    tick(2);
    bus.event_clear_i = 8'h00;

    // Bypass on bit 3 with a 1-cycle pad pulse
    bus.bypass_i = 8'h08;
    bus.pad_i    = 8'h08;
    tick(1);
    bus.pad_i = 8'h00;
    tick(1);
    chk("byp_e2_level", bus.level_o, 8'h00);
    tick(1);
    chk("byp_e3_level", bus.level_o, 8'h08);
    chk("byp_e3_rise",  bus.rise_o,  8'h08);
    tick(1);
    chk("byp_e4_level", bus.level_o, 8'h00);
    chk("byp_e4_fall",  bus.fall_o,  8'h08);
    chk("byp_e4_rise",  bus.rise_o,  8'h00);
    tick(1);
    chk("byp_e5_fall",  bus.fall_o,  8'h00);
    chk("byp_e5_event", bus.event_o, 8'h08);
    bus.bypass_i      = 8'h00;
    bus.event_clear_i = 8'hFF;
    tick(1);
    bus.event_clear_i = 8'h00;

    // Clear racing a set on bit 2
    bus.pad_i = 8'h04;
    tick(6);
    chk("race_e6_rise", bus.rise_o, 8'h04);
    bus.event_clear_i = 8'h04;
    tick(1);
    chk("race_set_wins", bus.event_o, 8'h04);
    tick(1);
    chk("race_second_clear", bus.event_o, 8'h00);
    bus.event_clear_i = 8'h00;

    // IRQ masking: bit 0 rises and bit 2 falls together -> event 05
    bus.irq_en_i = 8'h04;
    bus.pad_i    = 8'h01;
    tick(6);
    chk("irq_e6_irq", bus.irq_o, 1'b0);
    chk("irq_e6_level", bus.level_o, 8'h01);
    tick(1);
    chk("irq_e7_event", bus.event_o, 8'h05);
    chk("irq_en04", bus.irq_o, 1'b1);
    bus.irq_en_i = 8'h02;
    #1;
    chk("irq_en02", bus.irq_o, 1'b0);
    bus.irq_en_i = 8'h01;
    #1;
    chk("irq_en01", bus.irq_o, 1'b1);
    bus.irq_en_i      = 8'hFF;
    bus.event_clear_i = 8'hFF;
    tick(1);
    chk("irq_after_clear", bus.irq_o, 1'b0);
    bus.event_clear_i = 8'h00;

    // Async reset in the middle of bit 1 counting (cnt=2 after edge 4)
    bus.pad_i = 8'h03;
    tick(4);
    chk("mid_e4_level", bus.level_o, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", bus.level_o, 8'h00);
    chk("mid_rst_event", bus.event_o, 8'h00);
    chk("mid_rst_irq",   bus.irq_o,   1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("mid_e5_level", bus.level_o, 8'h00);
    chk("mid_e5_rise",  bus.rise_o,  8'h00);
    tick(1);
    chk("mid_e6_level", bus.level_o, 8'h03);
    chk("mid_e6_rise",  bus.rise_o,  8'h03);
    tick(1);
    chk("mid_e7_event", bus.event_o, 8'h03);
    chk("mid_e7_irq",   bus.irq_o,   1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
